step_pulse_receiver: RTL and testbench
======================================

Name: step_pulse_receiver

Overview:
- Receiving end of the stepper step/dir pulse interface.
- Samples an external step pulse line and direction line, validates each pulse's high width, and accumulates a signed position and a pulse count.
- Detects end-of-move by a low-time timeout and reports it with a one-tick strobe.
- Sits on the plotter's motor-feedback / self-test path, facing a pulse transmitter; all timing is measured in clk_en ticks.

Parameters:
- POS_WIDTH, 16: width of the position accumulator and the pulse counter.
- WIDTH_CNT_WIDTH, 16: width of the pulse-width measurement counter.
- MIN_PULSE, 2: minimum valid high width in ticks; must be >= 1.
- IDLE_TIMEOUT, 64: low ticks after the last pulse before the move is declared done; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  tick enable; all sampling, counting and state changes occur only on cycles with clk_en=1
- pulse_in  in  1  external step line, asynchronous
- dir_in  in  1  external direction line (1 = +1 per step, 0 = -1), asynchronous
- clear  in  1  synchronous clear of the accumulated results, qualified by clk_en
- position  out  POS_WIDTH  signed two's-complement step position
- pulse_count  out  POS_WIDTH  number of valid pulses, unsigned, saturating
- last_width  out  WIDTH_CNT_WIDTH  high width in ticks of the last valid pulse
- moving  out  1  high while a move is in progress (states HIGH and LOW)
- move_done  out  1  one-tick strobe when the idle timeout expires
- glitch_err  out  1  sticky flag: a pulse shorter than MIN_PULSE was seen

Behaviour:
- Reset (async) values: all outputs 0; synchronizer flops 0; width and idle counters 0; state ARM.
- Input conditioning:
  - pulse_in and dir_in each pass through a 2-flop synchronizer (s1, s2) plus an edge flop s3 on pulse_in, all advancing on clk_en.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An input change is first visible to the FSM 2 ticks after it is first sampled.
- States:
  - ARM: waits for synced pulse_in = 0, then goes to IDLE. This prevents a line that is already high at reset release from being counted.
  - IDLE: on rise, latch the synced dir, set width counter to 1, and go to HIGH.
  - HIGH: width counter increments each tick, saturating at all-ones. On fall:
    - if width >= MIN_PULSE: position +/- 1 per the latched dir, pulse_count +1, last_width = width;
    - otherwise: glitch_err set, nothing else changes.
    - In both cases go to LOW with the idle counter set to 1.
  - LOW: on rise, behave as in IDLE (latch dir, width = 1, go to HIGH). Otherwise the idle counter increments; when it equals IDLE_TIMEOUT, go to IDLE and pulse move_done for one tick.
- Timing:
  - Result registers update on the tick after fall is detected, i.e. 3 ticks after pulse_in is first sampled low.
  - move_done and the falling edge of moving occur together.
- Arithmetic:
  - position wraps modulo 2^POS_WIDTH, so max positive + 1 gives max negative.
  - pulse_count saturates at 2^POS_WIDTH - 1.
  - last_width records the saturated width value.
- clear:
  - Zeroes position, pulse_count, last_width and glitch_err.
  - Does not change the FSM state or moving.
  - Has priority over a same-tick result update, which is discarded.
- clk_en = 0: every register holds its value; move_done is held at 0 on non-enabled cycles.
- Reset mid-pulse: immediate return to reset values; the remainder of the pulse is ignored via ARM.

Optional Feature:
- Macro: STEP_RX_DIR_CHANGE_ERR_EN.
- Defined: in HIGH, a change of the synced dir from its latched value sets glitch_err, and that pulse is not counted even if its width is valid.
- Undefined: dir is sampled only at rise, and changes during HIGH are ignored.

Test Plan:
- Defaults except IDLE_TIMEOUT=8. After reset hold pulse_in low 4 ticks, then 5 pulses (4 high / 4 low ticks) with dir=1 -> position=5, pulse_count=5, last_width=4, glitch_err=0; moving=1 during the train; exactly one move_done, 8 ticks after the last fall detection, with moving cleared in the same tick.
- 3 pulses with dir=1, then 5 pulses with dir=0, width 3 -> position=16'hFFFE (-2), pulse_count=8, last_width=3.
- One pulse with 1 high tick, then one with 2 high ticks -> glitch_err=1 after the first; position=1, pulse_count=1, last_width=2.
- POS_WIDTH=4: 8 pulses with dir=1 -> position=4'b1000 (-8). Then 12 more pulses -> pulse_count saturates at 15.
- Assert reset while pulse_in is high mid-pulse; deassert while it is still high for 5 more ticks -> all outputs 0 and that pulse is not counted. The next full pulse gives position=1.
- clear asserted in the same tick as a valid fall detection -> position, pulse_count, last_width and glitch_err all 0. With STEP_RX_DIR_CHANGE_ERR_EN defined, toggling dir mid-pulse -> glitch_err=1 and position unchanged.

Source files
------------

// File: rtl/step_pulse_receiver_if.sv
// ---------------------------------------------------------------------------
// step_pulse_receiver_if
//
// Bundles the step/dir line side and the result side of the step pulse
// receiver.
//
// Signal protocol: there is no valid/ready handshake on this bus. The
// transmitter side (master) drives clk_en, pulse_in, dir_in and clear. The
// receiver side (slave) drives the results. Results are level outputs that
// are always valid. move_done is a single-tick strobe. glitch_err is sticky
// until clear or reset. Everything is qualified by clk_en.
//
// Parameters:
//   POS_WIDTH        width of position / pulse_count
//   WIDTH_CNT_WIDTH  width of last_width
//
// Signals:
//   clk_en       tick enable
//   pulse_in     external step line (asynchronous)
//   dir_in       external direction line (asynchronous, 1 = +1 per step)
//   clear        synchronous clear of the accumulated results
//   position     signed step position
//   pulse_count  saturating count of valid pulses
//   last_width   high width of the last valid pulse in ticks
//   moving       high while a move is in progress
//   move_done    one-tick strobe at end of move
//   glitch_err   sticky short-pulse / bad-pulse flag
// ---------------------------------------------------------------------------
interface step_pulse_receiver_if #(
  parameter int POS_WIDTH       = 16,
  parameter int WIDTH_CNT_WIDTH = 16
);
  logic                       clk_en;
  logic                       pulse_in;
  logic                       dir_in;
  logic                       clear;
  logic [POS_WIDTH-1:0]       position;
  logic [POS_WIDTH-1:0]       pulse_count;
  logic [WIDTH_CNT_WIDTH-1:0] last_width;
  logic                       moving;
  logic                       move_done;
  logic                       glitch_err;

  modport master (
    output clk_en, pulse_in, dir_in, clear,
    input  position, pulse_count, last_width, moving, move_done, glitch_err
  );

  modport slave (
    input  clk_en, pulse_in, dir_in, clear,
    output position, pulse_count, last_width, moving, move_done, glitch_err
  );
endinterface

// File: rtl/step_pulse_receiver.sv
// ---------------------------------------------------------------------------
// step_pulse_receiver
//
// Receiving end of a stepper step/dir pulse interface. The block synchronises
// the step and direction lines and checks the high width of each step pulse.
// It accumulates a signed position and a saturating pulse count. End of move
// is reported with a one-tick strobe after an idle (low) timeout. All timing
// is in clk_en ticks.
//
// Optional feature macro: STEP_RX_DIR_CHANGE_ERR_EN
//   When this macro is defined, a change of the synced direction while the
//   pulse is high flags glitch_err, and that pulse is not counted.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   bus        step_pulse_receiver_if.slave (lines in, results out)
//   state_dbg  current FSM state (0 ARM, 1 IDLE, 2 HIGH, 3 LOW)
// ---------------------------------------------------------------------------
module step_pulse_receiver #(
  parameter int POS_WIDTH       = 16,
  parameter int WIDTH_CNT_WIDTH = 16,
  parameter int MIN_PULSE       = 2,
  parameter int IDLE_TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  step_pulse_receiver_if.slave  bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // The idle counter also times the ARM settle period, so it needs at least 2 bits.
  localparam int IDLE_BITS = ($clog2(IDLE_TIMEOUT + 1) < 2) ? 2 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_BITS-1:0]       IDLE_LAST  = IDLE_BITS'(IDLE_TIMEOUT);
  localparam logic [IDLE_BITS-1:0]       ARM_SETTLE = IDLE_BITS'(2);
  localparam logic [IDLE_BITS-1:0]       IDLE_ONE   = IDLE_BITS'(1);
  localparam logic [WIDTH_CNT_WIDTH-1:0] MIN_W      = WIDTH_CNT_WIDTH'(MIN_PULSE);
  localparam logic [WIDTH_CNT_WIDTH-1:0] W_ONE      = WIDTH_CNT_WIDTH'(1);
  localparam logic [WIDTH_CNT_WIDTH-1:0] W_MAX      = '1;
  localparam logic [POS_WIDTH-1:0]       P_ONE      = POS_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]       CNT_MAX    = '1;

  state_t                     state;
  logic                       p_s1, p_s2, p_s3;
  logic                       d_s1, d_s2;
  logic                       dir_lat;
  logic [WIDTH_CNT_WIDTH-1:0] width_cnt;
  logic [IDLE_BITS-1:0]       idle_cnt;
  logic [POS_WIDTH-1:0]       position_r;
  logic [POS_WIDTH-1:0]       count_r;
  logic [WIDTH_CNT_WIDTH-1:0] last_w_r;
  logic                       moving_r;
  logic                       done_r;
  logic                       glitch_r;

  logic rise, fall, width_ok, pulse_ok;

  assign rise     = p_s2 & ~p_s3;
  assign fall     = ~p_s2 & p_s3;
  assign width_ok = (width_cnt >= MIN_W);

`ifdef STEP_RX_DIR_CHANGE_ERR_EN
  logic dir_bad;   // direction moved away from the latched value during this pulse
  logic dir_moved;
  assign dir_moved = (d_s2 != dir_lat);
  assign pulse_ok  = width_ok & ~dir_bad & ~dir_moved;
`else
  assign pulse_ok  = width_ok;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARM;
      p_s1       <= 1'b0;
      p_s2       <= 1'b0;
      p_s3       <= 1'b0;
      d_s1       <= 1'b0;
      d_s2       <= 1'b0;
      dir_lat    <= 1'b0;
      width_cnt  <= '0;
      idle_cnt   <= '0;
      position_r <= '0;
      count_r    <= '0;
      last_w_r   <= '0;
      moving_r   <= 1'b0;
      done_r     <= 1'b0;
      glitch_r   <= 1'b0;
`ifdef STEP_RX_DIR_CHANGE_ERR_EN
      dir_bad    <= 1'b0;
`endif
    end else begin
      // The strobe lasts one enabled tick and is never seen on idle cycles.
      done_r <= 1'b0;
      if (bus.clk_en) begin
        p_s1 <= bus.pulse_in;
        p_s2 <= p_s1;
        p_s3 <= p_s2;
        d_s1 <= bus.dir_in;
        d_s2 <= d_s1;

        case (state)
          // Let the synchroniser fill with real samples before trusting a
          // low level. Otherwise, a line that is already high at reset release
          // would look low for the first ticks and then produce a bogus rise.
          ARM: begin
            if (idle_cnt >= ARM_SETTLE && !p_s2) begin
              state    <= IDLE;
              idle_cnt <= '0;
            end else if (idle_cnt < ARM_SETTLE) begin
              idle_cnt <= idle_cnt + IDLE_ONE;
            end
          end

          IDLE: begin
            if (rise) begin
              state     <= HIGH;
              dir_lat   <= d_s2;
              width_cnt <= W_ONE;
              moving_r  <= 1'b1;
`ifdef STEP_RX_DIR_CHANGE_ERR_EN
              dir_bad   <= 1'b0;
`endif
            end
          end

          HIGH: begin
`ifdef STEP_RX_DIR_CHANGE_ERR_EN
            if (dir_moved) begin
              dir_bad  <= 1'b1;
              glitch_r <= 1'b1;
            end
`endif
            if (fall) begin
              state    <= LOW;
              idle_cnt <= IDLE_ONE;
              if (pulse_ok) begin
                position_r <= dir_lat ? position_r + P_ONE : position_r - P_ONE;
                if (count_r != CNT_MAX) count_r <= count_r + P_ONE;
                last_w_r   <= width_cnt;
              end else begin
                glitch_r <= 1'b1;
              end
            end else if (width_cnt != W_MAX) begin
              width_cnt <= width_cnt + W_ONE;
            end
          end

          LOW: begin
            if (rise) begin
              state     <= HIGH;
              dir_lat   <= d_s2;
              width_cnt <= W_ONE;
`ifdef STEP_RX_DIR_CHANGE_ERR_EN
              dir_bad   <= 1'b0;
`endif
            end else if (idle_cnt == IDLE_LAST) begin
              state    <= IDLE;
              moving_r <= 1'b0;
              done_r   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + IDLE_ONE;
            end
          end

          default: state <= ARM;
        endcase

        // Later assignment wins: clear discards any same-tick result update
        // but leaves the FSM and moving alone.
        if (bus.clear) begin
          position_r <= '0;
          count_r    <= '0;
          last_w_r   <= '0;
          glitch_r   <= 1'b0;
        end
      end
    end
  end

  assign bus.position    = position_r;
  assign bus.pulse_count = count_r;
  assign bus.last_width  = last_w_r;
  assign bus.moving      = moving_r;
  assign bus.move_done   = done_r;
  assign bus.glitch_err  = glitch_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_step_pulse_receiver.sv
// ---------------------------------------------------------------------------
// tb_step_pulse_receiver
//
// Directed bench for step_pulse_receiver. dut_a uses the default widths with
// IDLE_TIMEOUT=8. dut_b uses POS_WIDTH=4 for the wrap and saturation cases.
// Both DUTs share the same step/dir lines, clear and reset. Expected values
// are computed by hand from the pulse sequences.
// ---------------------------------------------------------------------------
module tb_step_pulse_receiver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic clk_en = 1'b1;
  logic pulse  = 1'b0;
  logic dir    = 1'b0;
  logic clear  = 1'b0;

  logic [1:0] state_a, state_b;

  step_pulse_receiver_if #(.POS_WIDTH(16), .WIDTH_CNT_WIDTH(16)) bus_a ();
  step_pulse_receiver_if #(.POS_WIDTH(4),  .WIDTH_CNT_WIDTH(16)) bus_b ();

  assign bus_a.clk_en   = clk_en;
  assign bus_a.pulse_in = pulse;
  assign bus_a.dir_in   = dir;
  assign bus_a.clear    = clear;
  assign bus_b.clk_en   = clk_en;
  assign bus_b.pulse_in = pulse;
  assign bus_b.dir_in   = dir;
  assign bus_b.clear    = clear;

  step_pulse_receiver #(
    .POS_WIDTH(16), .WIDTH_CNT_WIDTH(16), .MIN_PULSE(2), .IDLE_TIMEOUT(8)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .state_dbg(state_a)
  );

  step_pulse_receiver #(
    .POS_WIDTH(4), .WIDTH_CNT_WIDTH(16), .MIN_PULSE(2), .IDLE_TIMEOUT(8)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;
  int done_cnt  = 0;

  // move_done strobes from dut_a, sampled away from the active edge
  always @(negedge clk) if (bus_a.move_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance n clocks and land 1 ns after the last active edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d, input int hi, input int lo);
    dir   = d;
    pulse = 1'b1;
    tick(hi);
    pulse = 1'b0;
    tick(lo);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset values
    tick(2);
    check("rst_position",  32'(bus_a.position),    32'h0);
    check("rst_count",     32'(bus_a.pulse_count), 32'h0);
    check("rst_last_w",    32'(bus_a.last_width),  32'h0);
    check("rst_moving",    32'(bus_a.moving),      32'h0);
    check("rst_done",      32'(bus_a.move_done),   32'h0);
    check("rst_glitch",    32'(bus_a.glitch_err),  32'h0);
    check("rst_state_arm", 32'(state_a),           32'h0);
    reset = 1'b0;
    tick(4);

    // 1: five 4/4 pulses, dir=1, precise move_done timing
    send(1'b1, 4, 4);
    send(1'b1, 4, 4);
    check("t1_moving_mid", 32'(bus_a.moving), 32'h1);
    send(1'b1, 4, 4);
    send(1'b1, 4, 4);
    dir   = 1'b1;
    pulse = 1'b1;
    tick(4);
    pulse = 1'b0;
    tick(10);  // fall detected on edge 3, timeout lands on edge 11
    check("t1_done_early",   32'(bus_a.move_done), 32'h0);
    check("t1_moving_early", 32'(bus_a.moving),    32'h1);
    tick(1);
    check("t1_done_strobe",  32'(bus_a.move_done), 32'h1);
    check("t1_moving_clr",   32'(bus_a.moving),    32'h0);
    check("t1_state_idle",   32'(state_a),         32'h1);
    tick(1);
    check("t1_done_one_tick", 32'(bus_a.move_done), 32'h0);
    check("t1_position",  32'(bus_a.position),    32'd5);
    check("t1_count",     32'(bus_a.pulse_count), 32'd5);
    check("t1_last_w",    32'(bus_a.last_width),  32'd4);
    check("t1_glitch",    32'(bus_a.glitch_err),  32'h0);
    check("t1_done_total", 32'(done_cnt),         32'd1);

    // 2: 3 up, 5 down, width 3
    do_clear();
    check("t2_cleared", 32'(bus_a.position), 32'h0);
    for (int i = 0; i < 3; i++) send(1'b1, 3, 4);
    for (int i = 0; i < 5; i++) send(1'b0, 3, 4);
    check("t2_position", 32'(bus_a.position),    32'hFFFE);
    check("t2_count",    32'(bus_a.pulse_count), 32'd8);
    check("t2_last_w",   32'(bus_a.last_width),  32'd3);

    // 3: short pulse then minimum-width pulse
    do_clear();
    send(1'b1, 1, 4);
    check("t3_glitch_set",  32'(bus_a.glitch_err),  32'h1);
    check("t3_short_pos",   32'(bus_a.position),    32'h0);
    check("t3_short_count", 32'(bus_a.pulse_count), 32'h0);
    send(1'b1, 2, 4);
    check("t3_position", 32'(bus_a.position),    32'd1);
    check("t3_count",    32'(bus_a.pulse_count), 32'd1);
    check("t3_last_w",   32'(bus_a.last_width),  32'd2);
    check("t3_glitch",   32'(bus_a.glitch_err),  32'h1);

    // 4: 4-bit wrap and count saturation (dut_b), 16-bit reference (dut_a)
    do_clear();
    for (int i = 0; i < 8; i++) send(1'b1, 2, 3);
    check("t4_b_wrap_pos", 32'(bus_b.position),    32'h8);
    check("t4_b_count8",   32'(bus_b.pulse_count), 32'd8);
    for (int i = 0; i < 12; i++) send(1'b1, 2, 3);
    check("t4_b_count_sat", 32'(bus_b.pulse_count), 32'd15);
    check("t4_b_pos20",     32'(bus_b.position),    32'd4);
    check("t4_a_count20",   32'(bus_a.pulse_count), 32'd20);
    check("t4_a_pos20",     32'(bus_a.position),    32'd20);

    // 5: reset mid-pulse, line still high after release
    dir   = 1'b1;
    pulse = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    check("t5_rst_pos",    32'(bus_a.position),    32'h0);
    check("t5_rst_count",  32'(bus_a.pulse_count), 32'h0);
    check("t5_rst_moving", 32'(bus_a.moving),      32'h0);
    tick(1);
    reset = 1'b0;
    tick(5);
    pulse = 1'b0;
    tick(4);
    check("t5_ignored_pos",    32'(bus_a.position),    32'h0);
    check("t5_ignored_count",  32'(bus_a.pulse_count), 32'h0);
    check("t5_ignored_moving", 32'(bus_a.moving),      32'h0);
    send(1'b1, 3, 4);
    check("t5_next_pos",   32'(bus_a.position),    32'd1);
    check("t5_next_count", 32'(bus_a.pulse_count), 32'd1);

    // 6: clear on the same tick as a valid fall detection
    send(1'b1, 1, 4);
    check("t6_glitch_pre", 32'(bus_a.glitch_err), 32'h1);
    dir   = 1'b1;
    pulse = 1'b1;
    tick(3);
    pulse = 1'b0;
    tick(2);
    clear = 1'b1;   // third tick after first low sample: fall is detected here
    tick(1);
    clear = 1'b0;
    tick(3);
    check("t6_pos",    32'(bus_a.position),    32'h0);
    check("t6_count",  32'(bus_a.pulse_count), 32'h0);
    check("t6_last_w", 32'(bus_a.last_width),  32'h0);
    check("t6_glitch", 32'(bus_a.glitch_err),  32'h0);
    check("t6_moving", 32'(bus_a.moving),      32'h1);

    // clk_en low: a full pulse on the line is ignored entirely
    clk_en = 1'b0;
    pulse  = 1'b1;
    tick(6);
    pulse  = 1'b0;
    tick(6);
    clk_en = 1'b1;
    tick(4);
    check("t6_hold_count", 32'(bus_a.pulse_count), 32'h0);
    check("t6_hold_pos",   32'(bus_a.position),    32'h0);

    // 7: direction toggled mid-pulse
    dir   = 1'b1;
    pulse = 1'b1;
    tick(2);
    dir   = 1'b0;
    tick(2);
    pulse = 1'b0;
    tick(4);
`ifdef STEP_RX_DIR_CHANGE_ERR_EN
    check("t7_dir_glitch", 32'(bus_a.glitch_err),  32'h1);
    check("t7_dir_pos",    32'(bus_a.position),    32'h0);
    check("t7_dir_count",  32'(bus_a.pulse_count), 32'h0);
`else
    check("t7_dir_glitch", 32'(bus_a.glitch_err),  32'h0);
    check("t7_dir_pos",    32'(bus_a.position),    32'd1);
    check("t7_dir_count",  32'(bus_a.pulse_count), 32'd1);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
